// File: rtl/nest_checker.sv
// rtl/nest_checker.sv - begin/end keyword nesting checker over an ASCII byte stream
// Define NEST_CHECKER_FORK_EN to also track fork/join with a one-bit type stack.
module nest_checker #(
  parameter int DEPTH_W   = 4,
  parameter int CASE_SENS = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         in,
  input  logic               in_valid,
  output logic               result,
  output logic [DEPTH_W-1:0] depth,
  output logic               error
);
  localparam logic [DEPTH_W-1:0] MAX_D = {DEPTH_W{1'b1}};
  localparam logic [DEPTH_W-1:0] ONE   = DEPTH_W'(1);
`ifdef NEST_CHECKER_FORK_EN
  localparam int NKW     = 4;
  localparam int STACK_N = (1 << DEPTH_W) - 1;
`else
  localparam int NKW     = 2;
`endif

  typedef enum logic [2:0] {IDLE, MATCH, KW_OPEN, KW_CLOSE, OTHER} state_e;

  state_e             state_q, state_d;
  logic [2:0]         idx_q, idx_d;
  logic [NKW-1:0]     cand_q, cand_d;
  logic [DEPTH_W-1:0] cd_q, cd_d, depth_q, depth_d;
  logic               err_q, err_d, result_q, result_d;
`ifdef NEST_CHECKER_FORK_EN
  logic               type_q, type_d;
  logic [STACK_N-1:0] stack_q, stack_d;
`endif

  // Keyword k: 0 begin, 1 end, 2 fork, 3 join (even = opener).
  function automatic logic [7:0] kw_char(input int k, input logic [2:0] i);
    logic [39:0] s;
    int p;
    case (k)
      0:       s = "begin";
      1:       s = "end  ";
      2:       s = "fork ";
      default: s = "join ";
    endcase
    p = 39 - 8 * int'(i);
    return s[p -: 8];
  endfunction

  function automatic logic [2:0] kw_len(input int k);
    case (k)
      0:       return 3'd5;
      1:       return 3'd3;
      default: return 3'd4;
    endcase
  endfunction

  logic [7:0]         ch;
  logic               is_letter, done, done_open;
  logic [2:0]         pos;
  logic [NKW-1:0]     base, cand_n;
  logic [DEPTH_W-1:0] tdepth;
  logic               tbad;
`ifdef NEST_CHECKER_FORK_EN
  logic               done_fork;
`endif

  always_comb begin
    is_letter = (in >= 8'h41 && in <= 8'h5a) || (in >= 8'h61 && in <= 8'h7a);
    ch        = in;
    if (CASE_SENS == 0 && in >= 8'h41 && in <= 8'h5a) ch = in | 8'h20;
    pos       = (state_q == IDLE) ? 3'd0 : idx_q;
    base      = (state_q == IDLE) ? '1 : cand_q;
    cand_n    = '0;
    done      = 1'b0;
    done_open = 1'b0;
`ifdef NEST_CHECKER_FORK_EN
    done_fork = 1'b0;
`endif
    for (int k = 0; k < NKW; k++) begin
      if (base[k] && pos < kw_len(k) && kw_char(k, pos) == ch) begin
        cand_n[k] = 1'b1;
        if (pos + 3'd1 == kw_len(k)) begin
          done      = 1'b1;
          done_open = (k % 2 == 0);
`ifdef NEST_CHECKER_FORK_EN
          done_fork = (k >= 2);
`endif
        end
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cand_d   = cand_q;
    cd_d     = cd_q;
    err_d    = err_q;
    depth_d  = depth_q;
    result_d = result_q;
    tdepth   = cd_q;
    tbad     = 1'b0;
`ifdef NEST_CHECKER_FORK_EN
    type_d   = type_q;
    stack_d  = stack_q;
`endif
    if (in_valid) begin
      if (is_letter) begin
        if (state_q == IDLE || state_q == MATCH) begin
          idx_d  = pos + 3'd1;
          cand_d = cand_n;
          if (done) begin
            state_d = done_open ? KW_OPEN : KW_CLOSE;
`ifdef NEST_CHECKER_FORK_EN
            type_d  = done_fork;
`endif
          end else if (|cand_n) begin
            state_d = MATCH;
          end else begin
            state_d = OTHER;
          end
        end else begin
          state_d = OTHER;
        end
      end else begin
        // Delimiter: commit whatever complete keyword the word formed.
        state_d = IDLE;
        if (state_q == KW_OPEN) begin
          if (cd_q == MAX_D) begin
            err_d = 1'b1;
          end else begin
            cd_d = cd_q + ONE;
`ifdef NEST_CHECKER_FORK_EN
            stack_d[cd_q] = type_q;
`endif
          end
        end else if (state_q == KW_CLOSE) begin
          if (cd_q == '0) begin
            err_d = 1'b1;
          end else begin
            cd_d = cd_q - ONE;
`ifdef NEST_CHECKER_FORK_EN
            if (stack_q[cd_q - ONE] != type_q) err_d = 1'b1;
`endif
          end
        end
      end

      // Outputs show the depth as if the current word ended right now.
      tdepth = cd_d;
      if (state_d == KW_OPEN) begin
        tdepth = (cd_d == MAX_D) ? MAX_D : cd_d + ONE;
      end else if (state_d == KW_CLOSE) begin
        if (cd_d == '0) begin
          tbad = 1'b1;
        end else begin
          tdepth = cd_d - ONE;
`ifdef NEST_CHECKER_FORK_EN
          if (stack_q[cd_d - ONE] != type_d) tbad = 1'b1;
`endif
        end
      end
      depth_d  = tdepth;
      result_d = (tdepth == '0) && !err_d && !tbad;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      cand_q   <= '0;
      cd_q     <= '0;
      err_q    <= 1'b0;
      depth_q  <= '0;
      result_q <= 1'b1;
`ifdef NEST_CHECKER_FORK_EN
      type_q   <= 1'b0;
      stack_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cand_q   <= cand_d;
      cd_q     <= cd_d;
      err_q    <= err_d;
      depth_q  <= depth_d;
      result_q <= result_d;
`ifdef NEST_CHECKER_FORK_EN
      type_q   <= type_d;
      stack_q  <= stack_d;
`endif
    end
  end

  assign result = result_q;
  assign depth  = depth_q;
  assign error  = err_q;

endmodule

// File: doc/nest_checker.md
NEST_CHECKER -- requirements
Module: nest_checker

Interface
REQ-001 SHALL provide parameter DEPTH_W, default 4, width of the nesting-depth counter (max depth 2^DEPTH_W-1).
REQ-002 SHALL provide parameter CASE_SENS, default 0; 0 means keyword match ignores letter case, 1 means lowercase-only match.
REQ-003 SHALL provide port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL provide port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL provide port in  input  8  ASCII character of the stream.
REQ-006 SHALL provide port in_valid  input  1  in is consumed on a rising edge only when high.
REQ-007 SHALL provide port result  output  1  high when the stream so far is balanced and error-free.
REQ-008 SHALL provide port depth  output  DEPTH_W  current nesting depth.
REQ-009 SHALL provide port error  output  1  sticky underflow/overflow/mismatch flag.

Function
REQ-010 SHALL treat bytes A-Z/a-z as word characters; any other byte is a delimiter that terminates the current word.
REQ-011 SHALL recognise a word as opener only if it equals "begin" exactly and as closer only if it equals "end" exactly (per CASE_SENS); prefixes/extensions ("endc", "beginx") are ordinary words.
REQ-012 SHALL track a word-matcher FSM: IDLE, MATCH (prefix of a keyword so far), KW_OPEN, KW_CLOSE (complete keyword, not yet terminated), OTHER (non-keyword word); delimiter returns to IDLE and commits.
REQ-013 SHALL commit on delimiter: KW_OPEN increments committed depth; KW_CLOSE decrements; other states leave depth unchanged.
REQ-014 SHALL drive all outputs registered, updated on the same edge that consumes the byte (visible next cycle), with no extra latency.
REQ-015 SHALL drive depth and result tentatively, as if the current unfinished word were terminated now: depth = committed depth +1 in KW_OPEN, -1 in KW_CLOSE.
REQ-016 SHALL drive result = 1 only when tentative depth is 0, error is 0 and no tentative underflow exists.
REQ-017 SHALL set error on committing a closer at committed depth 0 (underflow); depth holds at 0.
REQ-018 SHALL set error on committing an opener at committed depth 2^DEPTH_W-1 (overflow); depth holds at max.
REQ-019 SHALL, once error is set, hold error=1 and result=0 until reset, while depth keeps tracking saturated values.
REQ-020 SHALL treat a tentative closer at depth 0 as result=0, depth=0, without setting error unless committed.
REQ-021 SHALL ignore in when in_valid is low; all state and outputs hold.

Reset
REQ-022 SHALL, when reset is high at a rising edge, force FSM to IDLE, depth=0, error=0, result=1, discarding any partial word; reset dominates in_valid.
REQ-023 SHALL apply reset mid-word or mid-nesting identically, with no residual state.

Configuration
REQ-024 SHALL, with macro NEST_CHECKER_FORK_EN defined, also recognise "fork" opener and "join" closer and keep a type stack of 2^DEPTH_W-1 one-bit entries; committing a closer whose type differs from top of stack sets error.
REQ-025 SHALL, without NEST_CHECKER_FORK_EN, treat "fork"/"join" as ordinary words and implement no type stack.

Verification
REQ-026 SHALL cover: reset, then "  ENd  " -> result 0 after 'd', error=1 after following space, result stays 0.
REQ-027 SHALL cover: "begin end " -> result 0 after 'n' of begin, depth 1; result 1 after 'd', error 0 at end.
REQ-028 SHALL cover: "begin endc " -> result 1 after 'd', 0 after 'c', depth 1, error 0.
REQ-029 SHALL cover: DEPTH_W=2, four "begin " words -> depth 3 then error=1 on fourth delimiter, depth 3.
REQ-030 SHALL cover: in_valid low for 5 cycles with varying in mid-word -> outputs unchanged; reset mid-"begi" -> result 1, depth 0.
REQ-031 SHALL cover (NEST_CHECKER_FORK_EN): "fork end " -> error=1 on final space; "fork join " -> result 1, error 0.
